i2c_command_scheduler: RTL and testbench

Drains the instruction buffers filled by the PC-side UART/I2C transmitter and sequences the I2C master through one complete register transaction per queued instruction. Write instructions become pointer plus data writes. Read instructions become pointer write, repeated start, and one or two byte reads. Read bytes, and optional error codes, are handed to the UART transmitter for return to the PC.

---
 rtl/bridge_pkg.sv | 41 ++++
 rtl/i2c_command_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_command_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the UART/I2C bridge: instruction mode bits, I2C master
// command codes and the command scheduler state encoding.
package bridge_pkg;

    localparam logic [7:0] MODE_RD1 = 8'h01;
    localparam logic [7:0] MODE_RD2 = 8'h02;
    localparam logic [7:0] MODE_WR1 = 8'h04;
    localparam logic [7:0] MODE_WR2 = 8'h08;

    localparam logic [2:0] I2C_START   = 3'd0;
    localparam logic [2:0] I2C_WR      = 3'd1;
    localparam logic [2:0] I2C_RD      = 3'd2;
    localparam logic [2:0] I2C_STOP    = 3'd3;
    localparam logic [2:0] I2C_RESTART = 3'd4;

    // Issue/wait sub-phase of every command and reply state.
    localparam logic [1:0] PH_ISSUE  = 2'd0;
    localparam logic [1:0] PH_STROBE = 2'd1;
    localparam logic [1:0] PH_WAIT   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_START   = 4'd2,
        S_ADDR_W  = 4'd3,
        S_POINTER = 4'd4,
        S_WR_DATA = 4'd5,
        S_RESTART = 4'd6,
        S_ADDR_R  = 4'd7,
        S_RD_DATA = 4'd8,
        S_STOP    = 4'd9,
        S_REPLY   = 4'd10
    } sched_state_t;

    // Exactly one of the four defined mode bits, upper nibble clear.
    function automatic logic mode_legal(input logic [7:0] m);
        return (m[7:4] == 4'h0) &&
               ((m[3:0] == 4'h1) || (m[3:0] == 4'h2) || (m[3:0] == 4'h4) || (m[3:0] == 4'h8));
    endfunction

endpackage

// File: rtl/i2c_command_scheduler.sv
// Turns queued PC instructions into complete I2C register transactions and returns
// read bytes to the UART. Define SCHED_ERR_REPORT_EN to also report NACK/illegal-mode codes.
module i2c_command_scheduler
    import bridge_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h48,
    parameter logic [7:0] ERR_NACK = 8'hEE,
    parameter logic [7:0] ERR_MODE = 8'hEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       buf_empty,
    input  logic [7:0] buf_addr,
    input  logic [7:0] buf_mode,
    input  logic [7:0] buf_data1,
    input  logic [7:0] buf_data2,
    output logic       rd_buffers,
    input  logic       i2c_ready,
    output logic [2:0] i2c_cmd,
    output logic [7:0] i2c_din,
    output logic       i2c_wr,
    input  logic       i2c_done_tick,
    input  logic       i2c_ack,
    input  logic [7:0] i2c_dout,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic [3:0] dbg_state
);

    sched_state_t state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [7:0] addr_q, addr_d, data1_q, data1_d, data2_q, data2_d;
    logic [7:0] rbuf0_q, rbuf0_d, rbuf1_q, rbuf1_d;
    logic       is_rd_q, is_rd_d, cnt_q, cnt_d, idx_q, idx_d, reply_idx_q, reply_idx_d;
    logic       nack_q, nack_d, mode_err_q, mode_err_d;
    logic       i2c_wr_q, i2c_wr_d, tx_start_q, tx_start_d;
    logic [2:0] i2c_cmd_q, i2c_cmd_d;
    logic [7:0] i2c_din_q, i2c_din_d, tx_data_q, tx_data_d;

    logic [2:0] cmd_cur;
    logic [7:0] din_cur, reply_byte;
    logic       byte_cmd, step, reply_last, legal;

    always_comb begin
        cmd_cur = I2C_START;
        din_cur = 8'h00;
        case (state_q)
            S_ADDR_W:  begin cmd_cur = I2C_WR;      din_cur = {DEV_ADDR, 1'b0}; end
            S_POINTER: begin cmd_cur = I2C_WR;      din_cur = addr_q; end
            S_WR_DATA: begin cmd_cur = I2C_WR;      din_cur = idx_q ? data2_q : data1_q; end
            S_RESTART: begin cmd_cur = I2C_RESTART; din_cur = 8'h00; end
            S_ADDR_R:  begin cmd_cur = I2C_WR;      din_cur = {DEV_ADDR, 1'b1}; end
            // Master ACKs every byte except the last one of the read.
            S_RD_DATA: begin cmd_cur = I2C_RD;      din_cur = {7'b0, idx_q == cnt_q}; end
            S_STOP:    begin cmd_cur = I2C_STOP;    din_cur = 8'h00; end
            default:   begin cmd_cur = I2C_START;   din_cur = 8'h00; end
        endcase
    end

    assign byte_cmd   = (cmd_cur == I2C_WR) || (cmd_cur == I2C_RD);
    assign step       = byte_cmd ? i2c_done_tick : i2c_ready;
    assign legal      = mode_legal(buf_mode);
    assign reply_last = nack_q || mode_err_q || (reply_idx_q == cnt_q);
    assign reply_byte = nack_q ? ERR_NACK : (mode_err_q ? ERR_MODE : (reply_idx_q ? rbuf1_q : rbuf0_q));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        rbuf0_d     = rbuf0_q;
        rbuf1_d     = rbuf1_q;
        is_rd_d     = is_rd_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        reply_idx_d = reply_idx_q;
        nack_d      = nack_q;
        mode_err_d  = mode_err_q;
        i2c_wr_d    = 1'b0;
        i2c_cmd_d   = i2c_cmd_q;
        i2c_din_d   = i2c_din_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        case (state_q)
            S_IDLE: if (!buf_empty) state_d = S_FETCH;
            S_FETCH: begin
                addr_d      = buf_addr;
                data1_d     = buf_data1;
                data2_d     = buf_data2;
                is_rd_d     = buf_mode[0] | buf_mode[1];
                cnt_d       = buf_mode[1] | buf_mode[3];
                idx_d       = 1'b0;
                reply_idx_d = 1'b0;
                nack_d      = 1'b0;
                mode_err_d  = !legal;
                phase_d     = PH_ISSUE;
                if (!legal) begin
`ifdef SCHED_ERR_REPORT_EN
                    state_d = S_REPLY;
`else
                    state_d = S_IDLE;
`endif
                end else if (i2c_ready) begin
                    // Issue START straight from FETCH so it strobes the very next cycle.
                    state_d   = S_START;
                    phase_d   = PH_STROBE;
                    i2c_wr_d  = 1'b1;
                    i2c_cmd_d = I2C_START;
                    i2c_din_d = 8'h00;
                end else begin
                    state_d = S_START;
                end
            end
            S_REPLY: begin
                if (phase_q == PH_ISSUE) begin
                    if (tx_ready) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = reply_byte;
                        phase_d    = PH_STROBE;
                    end
                end else begin
                    phase_d = PH_ISSUE;
                    if (reply_last) state_d = S_IDLE;
                    else reply_idx_d = 1'b1;
                end
            end
            default: begin
                case (phase_q)
                    PH_ISSUE: if (i2c_ready) begin
                        i2c_wr_d  = 1'b1;
                        i2c_cmd_d = cmd_cur;
                        i2c_din_d = din_cur;
                        phase_d   = PH_STROBE;
                    end
                    // The master only drops i2c_ready after it sees the strobe.
                    PH_STROBE: phase_d = PH_WAIT;
                    default: if (step) begin
                        phase_d = PH_ISSUE;
                        if ((cmd_cur == I2C_WR) && i2c_ack) begin
                            nack_d  = 1'b1;
                            state_d = S_STOP;
                        end else begin
                            case (state_q)
                                S_START:   state_d = S_ADDR_W;
                                S_ADDR_W:  state_d = S_POINTER;
                                S_POINTER: state_d = is_rd_q ? S_RESTART : S_WR_DATA;
                                S_WR_DATA: if (idx_q != cnt_q) idx_d = 1'b1;
                                           else state_d = S_STOP;
                                S_RESTART: state_d = S_ADDR_R;
                                S_ADDR_R:  state_d = S_RD_DATA;
                                S_RD_DATA: begin
                                    if (idx_q) rbuf1_d = i2c_dout;
                                    else rbuf0_d = i2c_dout;
                                    if (idx_q != cnt_q) idx_d = 1'b1;
                                    else state_d = S_STOP;
                                end
                                S_STOP: begin
                                    if (nack_q) begin
`ifdef SCHED_ERR_REPORT_EN
                                        state_d = S_REPLY;
`else
                                        state_d = S_IDLE;
`endif
                                    end else begin
                                        state_d = is_rd_q ? S_REPLY : S_IDLE;
                                    end
                                end
                                default: state_d = S_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_ISSUE;
            addr_q      <= 8'h00;
            data1_q     <= 8'h00;
            data2_q     <= 8'h00;
            rbuf0_q     <= 8'h00;
            rbuf1_q     <= 8'h00;
            is_rd_q     <= 1'b0;
            cnt_q       <= 1'b0;
            idx_q       <= 1'b0;
            reply_idx_q <= 1'b0;
            nack_q      <= 1'b0;
            mode_err_q  <= 1'b0;
            i2c_wr_q    <= 1'b0;
            i2c_cmd_q   <= 3'd0;
            i2c_din_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            rbuf0_q     <= rbuf0_d;
            rbuf1_q     <= rbuf1_d;
            is_rd_q     <= is_rd_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            reply_idx_q <= reply_idx_d;
            nack_q      <= nack_d;
            mode_err_q  <= mode_err_d;
            i2c_wr_q    <= i2c_wr_d;
            i2c_cmd_q   <= i2c_cmd_d;
            i2c_din_q   <= i2c_din_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign rd_buffers = (state_q == S_FETCH);
    assign busy       = (state_q != S_IDLE);
    assign i2c_wr     = i2c_wr_q;
    assign i2c_cmd    = i2c_cmd_q;
    assign i2c_din    = i2c_din_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_i2c_command_scheduler.sv
// Scoreboard bench for i2c_command_scheduler with behavioural I2C master, UART and
// instruction-buffer models; expected bus commands and UART bytes are queued per test.
module tb_i2c_command_scheduler;
  import bridge_pkg::*;

  logic       clk, reset;
  logic       buf_empty;
  logic [7:0] buf_addr, buf_mode, buf_data1, buf_data2;
  logic       rd_buffers;
  logic       i2c_ready;
  logic [2:0] i2c_cmd;
  logic [7:0] i2c_din;
  logic       i2c_wr;
  logic       i2c_done_tick, i2c_ack;
  logic [7:0] i2c_dout;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic [3:0] dbg_state;

  i2c_command_scheduler dut (
    .clk(clk), .reset(reset),
    .buf_empty(buf_empty), .buf_addr(buf_addr), .buf_mode(buf_mode),
    .buf_data1(buf_data1), .buf_data2(buf_data2), .rd_buffers(rd_buffers),
    .i2c_ready(i2c_ready), .i2c_cmd(i2c_cmd), .i2c_din(i2c_din), .i2c_wr(i2c_wr),
    .i2c_done_tick(i2c_done_tick), .i2c_ack(i2c_ack), .i2c_dout(i2c_dout),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [10:0] exp_i2c_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  rd_q[$];
  logic [31:0] buf_q[$];
  logic        nack_en = 1'b0;
  logic [7:0]  nack_din = 8'h00;
  int          tx_stall = 5;
  int          cyc = 0, pop_cyc = 0, pops = 0, busy_rises = 0;
  logic        busy_prev = 1'b0;
  logic        rd_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_buf();
    logic [31:0] e;
    if (buf_q.size() == 0) begin
      buf_empty = 1'b1;
      e = 32'h0;
    end else begin
      buf_empty = 1'b0;
      e = buf_q[0];
    end
    buf_addr  = e[31:24];
    buf_mode  = e[23:16];
    buf_data1 = e[15:8];
    buf_data2 = e[7:0];
  endtask

  task automatic push_entry(input logic [7:0] a, input logic [7:0] m,
                            input logic [7:0] d1, input logic [7:0] d2);
    buf_q.push_back({a, m, d1, d2});
    drive_buf();
  endtask

  task automatic exp_cmd(input logic [2:0] c, input logic [7:0] d);
    exp_i2c_q.push_back({c, d});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(exp_i2c_q.size() == 0 && exp_tx_q.size() == 0 && buf_q.size() == 0 &&
             !busy && i2c_ready && tx_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, {31'b0, n < 3000}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // instruction buffer: pop after the edge that ends the FETCH cycle
  initial begin
    logic p;
    drive_buf();
    forever begin
      @(negedge clk);
      p = rd_buffers;
      @(posedge clk);
      #1;
      if (p && buf_q.size() > 0) begin
        void'(buf_q.pop_front());
        drive_buf();
      end
    end
  end

  // I2C master model
  initial begin
    logic [2:0] c;
    logic [7:0] d;
    i2c_ready = 1'b1;
    i2c_done_tick = 1'b0;
    i2c_ack = 1'b0;
    i2c_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (i2c_wr) begin
        c = i2c_cmd;
        d = i2c_din;
        i2c_ready = 1'b0;
        repeat (3) @(negedge clk);
        if (c == I2C_WR || c == I2C_RD) begin
          i2c_done_tick = 1'b1;
          i2c_ack = (c == I2C_WR) && nack_en && (d == nack_din);
          if (c == I2C_RD && rd_q.size() > 0) i2c_dout = rd_q.pop_front();
          else i2c_dout = 8'h00;
          @(negedge clk);
          i2c_done_tick = 1'b0;
          i2c_ack = 1'b0;
        end
        i2c_ready = 1'b1;
      end
    end
  end

  // UART transmitter model
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_ready = 1'b0;
        repeat (tx_stall) @(negedge clk);
        tx_ready = 1'b1;
      end
    end
  end

  // monitor: pops expected entries whenever the DUT strobes
  always @(negedge clk) begin
    logic [10:0] e;
    cyc++;
    if (rd_buffers) begin
      pops++;
      pop_cyc = cyc;
    end
    if (busy && !busy_prev) busy_rises++;
    busy_prev = busy;
    if (i2c_wr) begin
      if (exp_i2c_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL i2c_unexpected: actual cmd=%0h din=%0h expected none", i2c_cmd, i2c_din);
      end else begin
        e = exp_i2c_q.pop_front();
        check("i2c_cmd_din", {21'b0, i2c_cmd, i2c_din}, {21'b0, e});
      end
      if (i2c_cmd == I2C_START) check("start_after_fetch", cyc - pop_cyc, 32'd1);
      if (i2c_cmd == I2C_RD) rd_seen = 1'b1;
    end
    if (tx_start) begin
      if (exp_tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: actual=%0h expected none", tx_data);
      end else begin
        check("tx_data", {24'b0, tx_data}, {24'b0, exp_tx_q.pop_front()});
      end
    end
  end

  // directed tests
  initial begin
    int p0, b0, n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_rd_buffers", {31'b0, rd_buffers}, 0);
    check("rst_i2c_wr", {31'b0, i2c_wr}, 0);
    check("rst_tx_start", {31'b0, tx_start}, 0);
    check("rst_i2c_cmd", {29'b0, i2c_cmd}, 0);
    check("rst_i2c_din", {24'b0, i2c_din}, 0);
    check("rst_tx_data", {24'b0, tx_data}, 0);
    check("rst_state", {28'b0, dbg_state}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_state", {28'b0, dbg_state}, 0);

    // 1: write two bytes
    p0 = pops;
    exp_cmd(I2C_START, 8'h00); exp_cmd(I2C_WR, 8'h90); exp_cmd(I2C_WR, 8'h03);
    exp_cmd(I2C_WR, 8'h4B);    exp_cmd(I2C_WR, 8'h00); exp_cmd(I2C_STOP, 8'h00);
    push_entry(8'h03, 8'h08, 8'h4B, 8'h00);
    wait_idle("wr2");
    check("wr2_pops", pops - p0, 1);

    // 2: read two bytes with a 5-cycle UART stall between replies
    p0 = pops;
    rd_q.push_back(8'h19); rd_q.push_back(8'h80);
    exp_cmd(I2C_START, 8'h00); exp_cmd(I2C_WR, 8'h90); exp_cmd(I2C_WR, 8'h00);
    exp_cmd(I2C_RESTART, 8'h00); exp_cmd(I2C_WR, 8'h91);
    exp_cmd(I2C_RD, 8'h00); exp_cmd(I2C_RD, 8'h01); exp_cmd(I2C_STOP, 8'h00);
    exp_tx_q.push_back(8'h19); exp_tx_q.push_back(8'h80);
    push_entry(8'h00, 8'h02, 8'h00, 8'h00);
    wait_idle("rd2");
    check("rd2_pops", pops - p0, 1);

    // 3: NACK on the register pointer of a 1-byte read
    p0 = pops;
    nack_en = 1'b1; nack_din = 8'h07;
    exp_cmd(I2C_START, 8'h00); exp_cmd(I2C_WR, 8'h90); exp_cmd(I2C_WR, 8'h07);
    exp_cmd(I2C_STOP, 8'h00);
`ifdef SCHED_ERR_REPORT_EN
    exp_tx_q.push_back(8'hEE);
`endif
    push_entry(8'h07, 8'h01, 8'h00, 8'h00);
    wait_idle("nack");
    nack_en = 1'b0;
    check("nack_pops", pops - p0, 1);

    // 4: illegal mode, two bits set
    p0 = pops;
`ifdef SCHED_ERR_REPORT_EN
    exp_tx_q.push_back(8'hEF);
`endif
    push_entry(8'h01, 8'h05, 8'h00, 8'h00);
    wait_idle("illegal");
    check("illegal_pops", pops - p0, 1);

    // 5: back-to-back write 1 byte then read 1 byte
    p0 = pops;
    b0 = busy_rises;
    rd_q.push_back(8'h5C);
    exp_cmd(I2C_START, 8'h00); exp_cmd(I2C_WR, 8'h90); exp_cmd(I2C_WR, 8'h10);
    exp_cmd(I2C_WR, 8'hAA);    exp_cmd(I2C_STOP, 8'h00);
    exp_cmd(I2C_START, 8'h00); exp_cmd(I2C_WR, 8'h90); exp_cmd(I2C_WR, 8'h11);
    exp_cmd(I2C_RESTART, 8'h00); exp_cmd(I2C_WR, 8'h91);
    exp_cmd(I2C_RD, 8'h01); exp_cmd(I2C_STOP, 8'h00);
    exp_tx_q.push_back(8'h5C);
    push_entry(8'h10, 8'h04, 8'hAA, 8'h00);
    push_entry(8'h11, 8'h01, 8'h00, 8'h00);
    wait_idle("b2b");
    check("b2b_pops", pops - p0, 2);
    check("b2b_busy_rises", busy_rises - b0, 2);

    // 6: asynchronous reset while waiting on the first read byte
    p0 = pops;
    rd_seen = 1'b0;
    rd_q.push_back(8'hAB);
    exp_cmd(I2C_START, 8'h00); exp_cmd(I2C_WR, 8'h90); exp_cmd(I2C_WR, 8'h22);
    exp_cmd(I2C_RESTART, 8'h00); exp_cmd(I2C_WR, 8'h91); exp_cmd(I2C_RD, 8'h00);
    push_entry(8'h22, 8'h02, 8'h00, 8'h00);
    n = 0;
    while (!rd_seen && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_rd", {31'b0, rd_seen}, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 0);
    check("rst_mid_state", {28'b0, dbg_state}, 0);
    check("rst_mid_i2c_cmd", {29'b0, i2c_cmd}, 0);
    check("rst_mid_i2c_din", {24'b0, i2c_din}, 0);
    check("rst_mid_i2c_wr", {31'b0, i2c_wr}, 0);
    check("rst_mid_tx_data", {24'b0, tx_data}, 0);
    check("rst_mid_rd_buffers", {31'b0, rd_buffers}, 0);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    rd_q.delete();
    exp_cmd(I2C_START, 8'h00); exp_cmd(I2C_WR, 8'h90); exp_cmd(I2C_WR, 8'h33);
    exp_cmd(I2C_WR, 8'hC3);    exp_cmd(I2C_STOP, 8'h00);
    push_entry(8'h33, 8'h04, 8'hC3, 8'h00);
    wait_idle("after_rst");
    check("after_rst_pops", pops - p0, 2);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
